// File: rtl/sram_controller_gen_if.sv
// sram_controller_gen_if: MEM-stage request/response bundle for the SRAM controller
interface sram_controller_gen_if #(
    parameter int DATA_W = 32
);
    logic                wr_en;
    logic                rd_en;
    logic [31:0]         address;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W/8-1:0] byte_en;
    logic [DATA_W-1:0]   read_data;
    logic                sram_freeze;
    logic                ready;

    modport master (
        output wr_en, rd_en, address, write_data, byte_en,
        input  read_data, sram_freeze, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, byte_en,
        output read_data, sram_freeze, ready
    );
endinterface

// File: rtl/sram_controller_gen.sv
// sram_controller_gen: splits DATA_W-bit MEM-stage accesses into 16-bit async SRAM beats
module sram_controller_gen #(
    parameter int DATA_W      = 32,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int TURNAROUND  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_controller_gen_if.slave bus,
    inout  wire  [15:0]          SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);
    localparam int BEATS = DATA_W / 16;
    localparam int OFF   = $clog2(DATA_W / 8);
    localparam int BB    = $clog2(BEATS);
    localparam int BW    = BB > 0 ? BB : 1;
    localparam logic [3:0]    WLAST = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]    TLAST = 4'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
    localparam logic [BW-1:0] BLAST = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, XFER, RECOVER, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                wr_q, wr_d;
    logic                req, wlast, drive;

    assign req   = bus.wr_en | bus.rd_en;
    assign wlast = wait_q == WLAST;
    assign drive = state_q == XFER && wr_q;

    // DQ is only ever driven while a write beat is on the bus
    assign SRAM_DQ = drive ? wdata_q[16*int'(beat_q) +: 16] : 16'bz;

    assign bus.ready       = state_q == DONE;
    assign bus.sram_freeze = state_q == IDLE ? req : state_q != DONE;
    assign bus.read_data   = rdata_q;

    // state and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
        end
    end

    // sequencing: latch request, walk beats with per-beat wait count, recover, complete
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = XFER;
                wait_d  = '0;
                beat_d  = '0;
                addr_d  = bus.address;
                wdata_d = bus.write_data;
                be_d    = bus.byte_en;
                wr_d    = bus.wr_en & ~bus.rd_en;
            end
            XFER: begin
                if (!wr_q && wlast) rdata_d[16*int'(beat_q) +: 16] = SRAM_DQ;
                wait_d = wlast ? '0 : wait_q + 4'd1;
                beat_d = wlast && beat_q != BLAST ? beat_q + BW'(1) : beat_q;
                if (wlast && beat_q == BLAST) state_d = TURNAROUND == 0 ? DONE : RECOVER;
            end
            RECOVER: begin
                wait_d  = wait_q == TLAST ? '0 : wait_q + 4'd1;
                state_d = wait_q == TLAST ? DONE : RECOVER;
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM strobes and beat address, all inactive outside XFER
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_ADDR = '0;
        if (state_q == XFER) begin
            SRAM_CE_N = 1'b0;
            SRAM_WE_N = ~wr_q;
            SRAM_OE_N = wr_q;
            SRAM_UB_N = wr_q & ~be_q[2*int'(beat_q)+1];
            SRAM_LB_N = wr_q & ~be_q[2*int'(beat_q)];
            SRAM_ADDR = SRAM_AW'(((addr_q >> OFF) << BB) | 32'(beat_q));
        end
    end
endmodule

// File: tb/tb_sram_controller_gen.sv
// tb_sram_controller_gen: directed scoreboard bench for a default and a 64-bit controller
module tb_sram_controller_gen;
    logic clk, rst_n;
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;

    typedef struct {
        bit          rd;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t q1[$], q2[$];
    exp_t e;

    sram_controller_gen_if #(.DATA_W(32)) b1();
    sram_controller_gen_if #(.DATA_W(64)) b2();

    wire  [15:0] dq1, dq2;
    logic [17:0] a1, a2;
    logic we1, ce1, oe1, ub1, lb1;
    logic we2, ce2, oe2, ub2, lb2;
    logic [15:0] mem1 [1024];
    logic [15:0] mem2 [1024];

    sram_controller_gen u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .SRAM_DQ(dq1), .SRAM_ADDR(a1),
        .SRAM_WE_N(we1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    sram_controller_gen #(.DATA_W(64), .SRAM_AW(18), .WAIT_CYCLES(3), .TURNAROUND(0)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2), .SRAM_DQ(dq2), .SRAM_ADDR(a2),
        .SRAM_WE_N(we2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 16'h0;
            mem2[i] = 16'h0;
        end
    end

    // async SRAM models with byte lanes
    assign dq1 = (!ce1 && !oe1 && we1) ? mem1[a1[9:0]] : 16'bz;
    assign dq2 = (!ce2 && !oe2 && we2) ? mem2[a2[9:0]] : 16'bz;

    always @(posedge clk) begin
        if (!ce1 && !we1) begin
            if (!lb1) mem1[a1[9:0]][7:0]  <= dq1[7:0];
            if (!ub1) mem1[a1[9:0]][15:8] <= dq1[15:8];
        end
        if (!ce2 && !we2) begin
            if (!lb2) mem2[a2[9:0]][7:0]  <= dq2[7:0];
            if (!ub2) mem2[a2[9:0]][15:8] <= dq2[15:8];
        end
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        n_cmp++;
        if (a !== x) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
        b1.wr_en = w;
        b1.rd_en = r;
        b1.address = a;
        b1.write_data = d;
        b1.byte_en = be;
    endtask

    task automatic rd1(input logic [31:0] a, input logic [63:0] x);
        req1(1'b0, 1'b1, a, 32'h0, 4'h0);
        q1.push_back('{1'b1, x, cyc + 4});
        tick();
        b1.rd_en = 1'b0;
        repeat (4) tick();
    endtask

    // monitor: every ready pulse must match the oldest expectation of that port
    always @(negedge clk) begin
        if (b1.ready) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d1_ready: got unexpected ready at cycle %0d required none", cyc);
            end else begin
                e = q1.pop_front();
                chk("d1_ready_cycle", 64'(cyc), 64'(e.cyc));
                if (e.rd) chk("d1_read_data", 64'(b1.read_data), e.data);
            end
        end
        if (b2.ready) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d2_ready: got unexpected ready at cycle %0d required none", cyc);
            end else begin
                e = q2.pop_front();
                chk("d2_ready_cycle", 64'(cyc), 64'(e.cyc));
                if (e.rd) chk("d2_read_data", b2.read_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int n, wl;
        logic [63:0] d64;
        rst_n = 1'b0;
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        b2.wr_en = 1'b0;
        b2.rd_en = 1'b0;
        b2.address = 32'h0;
        b2.write_data = 64'h0;
        b2.byte_en = 8'h0;
        #3;
        chk("rst_ready", 64'(b1.ready), 64'(0));
        chk("rst_freeze", 64'(b1.sram_freeze), 64'(0));
        chk("rst_strobes", 64'({we1, ce1, oe1, ub1, lb1}), 64'(5'h1F));
        chk("rst_addr", 64'(a1), 64'(0));
        chk("rst_rdata", 64'(b1.read_data), 64'(0));
        chk("rst_strobes2", 64'({we2, ce2, oe2, ub2, lb2}), 64'(5'h1F));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // full-word write with default timing
        n = cyc;
        req1(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
        q1.push_back('{1'b0, 64'h0, n + 4});
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                tick();
                b1.wr_en = 1'b0;
            end
            @(negedge clk);
            chk("t1_freeze", 64'(b1.sram_freeze), 64'(k < 4));
            chk("t1_we_n", 64'(we1), 64'(!(k == 1 || k == 2)));
            if (k == 1 || k == 2) begin
                chk("t1_addr", 64'(a1), 64'(18'h80 + k - 1));
                chk("t1_dq", 64'(dq1), 64'(k == 1 ? 16'hBEEF : 16'hDEAD));
                chk("t1_lanes", 64'({ub1, lb1}), 64'(0));
            end
        end
        tick();
        rd1(32'h100, 64'hDEADBEEF);

        // single byte-lane write into byte 2
        req1(1'b1, 1'b0, 32'h100, 32'h11223344, 4'b0100);
        q1.push_back('{1'b0, 64'h0, cyc + 4});
        for (int k = 1; k <= 2; k++) begin
            tick();
            b1.wr_en = 1'b0;
            @(negedge clk);
            chk("t3_we_n", 64'(we1), 64'(0));
            chk("t3_ub_lb", 64'({ub1, lb1}), 64'(k == 1 ? 2'b11 : 2'b10));
        end
        repeat (3) tick();
        rd1(32'h100, 64'hDE22BEEF);

        // 64-bit, three wait states, no turnaround
        d64 = 64'h0123456789ABCDEF;
        n = cyc;
        b2.wr_en = 1'b1;
        b2.address = 32'h208;
        b2.write_data = d64;
        b2.byte_en = 8'hFF;
        q2.push_back('{1'b0, 64'h0, n + 13});
        for (int k = 1; k <= 13; k++) begin
            tick();
            b2.wr_en = 1'b0;
            @(negedge clk);
            if (k <= 12) begin
                chk("t4_addr", 64'(a2), 64'(18'h104 + (k - 1) / 3));
                chk("t4_we_n", 64'(we2), 64'(0));
                chk("t4_dq", 64'(dq2), 64'(d64[16*((k-1)/3) +: 16]));
            end else begin
                chk("t4_idle_strobes", 64'({we2, ce2}), 64'(2'b11));
            end
        end
        tick();
        b2.rd_en = 1'b1;
        q2.push_back('{1'b1, d64, cyc + 13});
        tick();
        b2.rd_en = 1'b0;
        repeat (13) tick();

        // simultaneous read and write request is a read
        req1(1'b1, 1'b1, 32'h100, 32'h55555555, 4'hF);
        q1.push_back('{1'b1, 64'hDE22BEEF, cyc + 4});
        wl = 0;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                tick();
                b1.wr_en = 1'b0;
                b1.rd_en = 1'b0;
            end
            @(negedge clk);
            if (!we1) wl++;
            if (k == 1) chk("t5_read_strobes", 64'({oe1, ub1, lb1}), 64'(0));
        end
        chk("t5_we_never_low", 64'(wl), 64'(0));
        tick();

        // request held high: second access starts the cycle after DONE
        n = cyc;
        req1(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
        q1.push_back('{1'b1, 64'hDE22BEEF, n + 4});
        q1.push_back('{1'b1, 64'hDE22BEEF, n + 9});
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            if (k == 4) chk("t5_freeze_done", 64'(b1.sram_freeze), 64'(0));
            if (k == 5) chk("t5_freeze_b2b", 64'(b1.sram_freeze), 64'(1));
        end
        tick();
        b1.rd_en = 1'b0;
        repeat (4) tick();

        // reset during write beat 1
        req1(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 4'hF);
        tick();
        b1.wr_en = 1'b0;
        tick();
        chk("t6_we_before", 64'(we1), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_we_n", 64'(we1), 64'(1));
        chk("t6_ce_n", 64'(ce1), 64'(1));
        chk("t6_freeze", 64'(b1.sram_freeze), 64'(0));
        chk("t6_ready", 64'(b1.ready), 64'(0));
        chk("t6_rdata", 64'(b1.read_data), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        rd1(32'h100, 64'hDE22F00D);

        for (int i = 0; i < 30 && (q1.size() != 0 || q2.size() != 0); i++) tick();
        chk("sb_drain", 64'(q1.size() + q2.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
